// File: rtl/aftab_aau_pkg.sv
// Shared definitions for the AAU multiply sequencer: RISC-V M-extension
// multiply opcodes and the sequencer state encoding.
`timescale 1ns/1ps
package aftab_aau_pkg;

    localparam int AAU_LEN = 32;

    localparam logic [1:0] MUL_OP    = 2'b00;
    localparam logic [1:0] MULH_OP   = 2'b01;
    localparam logic [1:0] MULHSU_OP = 2'b10;
    localparam logic [1:0] MULHU_OP  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        WAIT  = 2'b10,
        DONE  = 2'b11
    } mulState_t;

    // Every multiply flavour except MUL returns the upper product word.
    function automatic logic isHighOp(input logic [1:0] op);
        return (op != MUL_OP);
    endfunction

endpackage

// File: rtl/aftab_mul_operand_extender.sv
// Widens both operands to len+1 bits so the signed Booth multiplier can
// handle signed, mixed and unsigned flavours with one datapath.
`timescale 1ns/1ps
module aftab_mul_operand_extender
    import aftab_aau_pkg::*;
#(
    parameter int len = AAU_LEN
) (
    input  logic [1:0]     mulOp,
    input  logic [len-1:0] A,
    input  logic [len-1:0] B,
    output logic [len:0]   M,
    output logic [len:0]   Mr,
    output logic           selHigh
);

    logic w_signA;
    logic w_signB;

    // MULHSU treats only rs1 as signed; MULHU treats neither as signed.
    assign w_signA = (mulOp != MULHU_OP);
    assign w_signB = (mulOp == MUL_OP) || (mulOp == MULH_OP);

    assign M       = {w_signA & A[len-1], A};
    assign Mr      = {w_signB & B[len-1], B};
    assign selHigh = isHighOp(mulOp);

endmodule

// File: rtl/aftab_aau_mul_sequencer.sv
// Sequences one M-extension multiply through the AAU Booth multiplier:
// latch and extend operands, pulse start, await done, select the result word.
`timescale 1ns/1ps
module aftab_aau_mul_sequencer
    import aftab_aau_pkg::*;
#(
    parameter int len = AAU_LEN
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               startMul,
    input  logic [1:0]         mulOp,
    input  logic [len-1:0]     operandA,
    input  logic [len-1:0]     operandB,
    output logic               busy,
    output logic               mulDoneOut,
    output logic [len-1:0]     result,
    output logic [len:0]       boothM,
    output logic [len:0]       boothMr,
    output logic               boothStart,
    input  logic               boothDone,
    input  logic [2*len+1:0]   boothP
);

    mulState_t      r_state;
    logic [1:0]     r_mulOp;
    logic [len-1:0] r_operandA;
    logic [len-1:0] r_operandB;
    logic [len-1:0] r_result;
    logic           r_busy;
    logic           r_mulDoneOut;
    logic           r_boothStart;

    logic           w_selHigh;
    logic [len-1:0] w_productWord;
    logic           w_unusedProductTop;

    aftab_mul_operand_extender #(
        .len     (len)
    ) u_extender (
        .mulOp   (r_mulOp),
        .A       (r_operandA),
        .B       (r_operandB),
        .M       (boothM),
        .Mr      (boothMr),
        .selHigh (w_selHigh)
    );

    // The two sign-extension bits of the 66-bit product never carry result data.
    assign w_unusedProductTop = ^boothP[2*len+1:2*len];
    assign w_productWord      = w_selHigh ? boothP[2*len-1:len] : boothP[len-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_mulOp      <= '0;
            r_operandA   <= '0;
            r_operandB   <= '0;
            r_result     <= '0;
            r_busy       <= 1'b0;
            r_mulDoneOut <= 1'b0;
            r_boothStart <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_mulDoneOut <= 1'b0;
                    if (startMul) begin
                        r_mulOp      <= mulOp;
                        r_operandA   <= operandA;
                        r_operandB   <= operandB;
                        r_boothStart <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= START;
                    end
                end
                START: begin
                    r_boothStart <= 1'b0;
                    r_state      <= WAIT;
                end
                WAIT: begin
                    if (boothDone) begin
                        r_result     <= w_productWord;
                        r_mulDoneOut <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= DONE;
                    end
                end
                DONE: begin
                    // A request arriving in the completion cycle starts the next multiply directly.
                    r_mulDoneOut <= 1'b0;
                    if (startMul) begin
                        r_mulOp      <= mulOp;
                        r_operandA   <= operandA;
                        r_operandB   <= operandB;
                        r_boothStart <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= START;
                    end else begin
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign mulDoneOut = r_mulDoneOut;
    assign boothStart = r_boothStart;
    assign result     = r_result;

endmodule
